// File: rtl/axi4s_packet_arbiter.sv
// Packet-level round-robin arbiter: grants one byte-wide AXI4-Stream channel per
// tlast-delimited packet, optionally prefixing each packet with a channel-ID byte.
module axi4s_packet_arbiter #(
  parameter int          NUM_CH    = 4,
  parameter logic        INSERT_ID = 1'b1,
  parameter logic [7:0]  ID_BASE   = 8'h00,
  localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [NUM_CH-1:0]   target_tvalid,
  output logic [NUM_CH-1:0]   target_tready,
  input  logic [8*NUM_CH-1:0] target_tdata,
  input  logic [NUM_CH-1:0]   target_tlast,
  output logic                initiator_tvalid,
  input  logic                initiator_tready,
  output logic [7:0]          initiator_tdata,
  output logic                initiator_tlast,
  output logic                busy,
  output logic [CH_W-1:0]     active_ch
);

  typedef enum logic {IDLE, FORWARD} state_t;

  localparam logic [CH_W:0] NUM_CH_W = (CH_W+1)'(NUM_CH);

  state_t          state_reg, state_next;
  logic [CH_W-1:0] ptr_reg, ptr_next;
  logic [CH_W-1:0] active_ch_reg, active_ch_next;
  logic            out_valid_reg, out_valid_next;
  logic [7:0]      out_data_reg, out_data_next;
  logic            out_last_reg, out_last_next;

  logic            free;
  logic            sel_found;
  logic [CH_W-1:0] sel_ch;
  logic [CH_W:0]   scan_idx;
  logic            beat_valid;
  logic            beat_last;
  logic [7:0]      beat_data;
  logic            beat_hs;

  assign free = !out_valid_reg || initiator_tready;

  // Scan from ptr downwards in priority so the lowest offset from ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    scan_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      scan_idx = {1'b0, ptr_reg} + (CH_W+1)'(i);
      if (scan_idx >= NUM_CH_W) begin
        scan_idx = scan_idx - NUM_CH_W;
      end
      if (target_tvalid[scan_idx[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = scan_idx[CH_W-1:0];
      end
    end
  end

  assign beat_valid = target_tvalid[active_ch_reg];
  assign beat_last  = target_tlast[active_ch_reg];
  assign beat_data  = target_tdata[{active_ch_reg, 3'b000} +: 8];
  assign beat_hs    = (state_reg == FORWARD) && free && beat_valid;

  always_comb begin
    target_tready = '0;
    if (state_reg == FORWARD) begin
      target_tready[active_ch_reg] = free;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    active_ch_next = active_ch_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;

    if (out_valid_reg && initiator_tready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (sel_found && free) begin
          state_next     = FORWARD;
          active_ch_next = sel_ch;
          if (INSERT_ID) begin
            out_valid_next = 1'b1;
            out_data_next  = ID_BASE + 8'(sel_ch);
            out_last_next  = 1'b0;
          end
        end
      end
      FORWARD: begin
        if (beat_hs) begin
          out_valid_next = 1'b1;
          out_data_next  = beat_data;
          out_last_next  = beat_last;
          if (beat_last) begin
            state_next = IDLE;
            // Just-served channel drops to lowest priority.
            if ({1'b0, active_ch_reg} == NUM_CH_W - 1'b1) begin
              ptr_next = '0;
            end else begin
              ptr_next = active_ch_reg + 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      active_ch_reg <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'h00;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      active_ch_reg <= active_ch_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign initiator_tvalid = out_valid_reg;
  assign initiator_tdata  = out_data_reg;
  assign initiator_tlast  = out_last_reg;
  assign busy             = (state_reg == FORWARD);
  assign active_ch        = active_ch_reg;

endmodule

// File: tb/tb_axi4s_packet_arbiter.sv
// Bench for axi4s_packet_arbiter: packet-queue round-robin model plus directed
// literal checks on an ID-inserting instance and an ID-less instance.
module tb_axi4s_packet_arbiter;

  localparam int         NCH = 4;
  localparam logic [7:0] IDB = 8'hA0;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [NCH-1:0]   tv, tr, tl;
  logic [8*NCH-1:0] td;
  logic             ov, ordy, ol, busy;
  logic [7:0]       od;
  logic [1:0]       ach;

  logic [NCH-1:0]   tv0, tr0, tl0;
  logic [8*NCH-1:0] td0;
  logic             ov0, ordy0, ol0, busy0;
  logic [7:0]       od0;
  logic [1:0]       ach0;

  axi4s_packet_arbiter #(.NUM_CH(NCH), .INSERT_ID(1'b1), .ID_BASE(IDB)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .target_tvalid(tv), .target_tready(tr), .target_tdata(td), .target_tlast(tl),
    .initiator_tvalid(ov), .initiator_tready(ordy), .initiator_tdata(od),
    .initiator_tlast(ol), .busy(busy), .active_ch(ach)
  );

  axi4s_packet_arbiter #(.NUM_CH(NCH), .INSERT_ID(1'b0), .ID_BASE(8'h00)) u_dut_noid (
    .aclk(aclk), .aresetn(aresetn),
    .target_tvalid(tv0), .target_tready(tr0), .target_tdata(td0), .target_tlast(tl0),
    .initiator_tvalid(ov0), .initiator_tready(ordy0), .initiator_tdata(od0),
    .initiator_tlast(ol0), .busy(busy0), .active_ch(ach0)
  );

  // Source queues (what each channel still has to send) and model state.
  logic [7:0] src_d [NCH][$];
  bit         src_l [NCH][$];
  logic [7:0] s0_d  [NCH][$];
  bit         s0_l  [NCH][$];
  logic [7:0] pend_d [NCH][$];
  bit         pend_l [NCH][$];
  logic [7:0] exp_d [$];
  bit         exp_l [$];
  int         m_ptr;

  logic [NCH-1:0] hs, hs0;
  bit             rand_ready;
  bit             logging;
  bit             log_v [$], log_l [$], log_b [$];
  logic [7:0]     log_d [$];
  int             log_ch [$];
  bit             log_v0 [$], log_l0 [$];
  logic [7:0]     log_d0 [$];
  int             grants [$];

  bit         prev_ok, prev_valid, prev_ready, prev_l;
  logic [7:0] prev_d;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] t1_exp [4] = '{8'hA0, 8'h11, 8'h22, 8'h33};

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic add_pkt(input int c, input int len, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i) * step;
      src_d[c].push_back(b);
      src_l[c].push_back(i == len - 1);
      pend_d[c].push_back(b);
      pend_l[c].push_back(i == len - 1);
    end
  endtask

  // Round-robin over whole queued packets: each one becomes ID + payload.
  task automatic model_release();
    int  c;
    bit  any, last;
    forever begin
      any = 0;
      c = 0;
      for (int k = 0; k < NCH; k++) begin
        if (!any && pend_d[(m_ptr + k) % NCH].size() > 0) begin
          any = 1;
          c = (m_ptr + k) % NCH;
        end
      end
      if (!any) break;
      exp_d.push_back(IDB + 8'(c));
      exp_l.push_back(1'b0);
      do begin
        last = pend_l[c].pop_front();
        exp_d.push_back(pend_d[c].pop_front());
        exp_l.push_back(last);
      end while (!last);
      m_ptr = (c + 1) % NCH;
    end
  endtask

  function automatic bit sources_empty();
    for (int c = 0; c < NCH; c++) begin
      if (src_d[c].size() != 0 || s0_d[c].size() != 0) return 0;
    end
    return 1;
  endfunction

  task automatic driver_loop();
    forever begin
      @(posedge aclk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (hs[c] && src_d[c].size() > 0) begin
          void'(src_d[c].pop_front());
          void'(src_l[c].pop_front());
        end
        if (hs0[c] && s0_d[c].size() > 0) begin
          void'(s0_d[c].pop_front());
          void'(s0_l[c].pop_front());
        end
      end
      tv = '0; td = '0; tl = '0;
      tv0 = '0; td0 = '0; tl0 = '0;
      for (int c = 0; c < NCH; c++) begin
        if (src_d[c].size() > 0) begin
          tv[c] = 1'b1;
          td[8*c +: 8] = src_d[c][0];
          tl[c] = src_l[c][0];
        end
        if (s0_d[c].size() > 0) begin
          tv0[c] = 1'b1;
          td0[8*c +: 8] = s0_d[c][0];
          tl0[c] = s0_l[c][0];
        end
      end
      ordy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge aclk);
      hs  = tv & tr;
      hs0 = tv0 & tr0;
      if (logging) begin
        log_v.push_back(ov); log_d.push_back(od); log_l.push_back(ol);
        log_b.push_back(busy); log_ch.push_back(int'(ach));
        log_v0.push_back(ov0); log_d0.push_back(od0); log_l0.push_back(ol0);
      end
      if (aresetn) begin
        if (prev_ok && prev_valid && !prev_ready) begin
          chk("hold_valid", int'(ov), 1);
          chk("hold_data", int'(od), int'(prev_d));
          chk("hold_last", int'(ol), int'(prev_l));
        end
        if (ov && ordy) begin
          if (exp_d.size() == 0) begin
            chk("unexpected_beat", int'(od), -1);
          end else begin
            chk("out_data", int'(od), int'(exp_d.pop_front()));
            chk("out_last", int'(ol), int'(exp_l.pop_front()));
          end
        end
        prev_ok = 1; prev_valid = ov; prev_ready = ordy; prev_d = od; prev_l = ol;
      end else begin
        prev_ok = 0;
      end
    end
  endtask

  task automatic clear_logs();
    log_v.delete(); log_d.delete(); log_l.delete(); log_b.delete(); log_ch.delete();
    log_v0.delete(); log_d0.delete(); log_l0.delete();
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_tvalid", int'(ov), 0);
    chk("rst_tdata", int'(od), 0);
    chk("rst_tlast", int'(ol), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_active_ch", int'(ach), 0);
    chk("rst_tready", int'(tr), 0);
    for (int c = 0; c < NCH; c++) begin
      src_d[c].delete(); src_l[c].delete(); s0_d[c].delete(); s0_l[c].delete();
      pend_d[c].delete(); pend_l[c].delete();
    end
    exp_d.delete(); exp_l.delete();
    m_ptr = 0;
    rand_ready = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !(exp_d.size() == 0 && !busy && !ov && sources_empty())) begin
      @(negedge aclk);
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL %s_drain: timed out with %0d expected bytes left, required 0", name, exp_d.size());
    end
  endtask

  task automatic wait_grant(input string name, input int ch, input int budget);
    int n = 0;
    while (n < budget && !(busy && int'(ach) == ch)) begin
      @(negedge aclk);
      n++;
    end
    chk({name, "_granted"}, int'(n < budget), 1);
  endtask

  task automatic collect_grants();
    grants.delete();
    for (int i = 0; i < log_b.size(); i++) begin
      if (log_b[i] && (i == 0 || !log_b[i-1])) grants.push_back(log_ch[i]);
    end
  endtask

  initial begin
    int k, cnt;
    tv = '0; td = '0; tl = '0; tv0 = '0; td0 = '0; tl0 = '0;
    ordy = 1'b1; ordy0 = 1'b1;
    rand_ready = 0; logging = 0; m_ptr = 0; prev_ok = 0;
    hs = '0; hs0 = '0;
    fork
      compare_loop();
      driver_loop();
    join_none

    // Single channel-0 packet 11,22,33.
    apply_reset();
    clear_logs(); logging = 1;
    add_pkt(0, 3, 8'h11, 8'h11);
    model_release();
    repeat (12) @(negedge aclk);
    logging = 0;
    wait_drain("t1", 50);
    k = -1; cnt = 0;
    for (int i = 0; i < log_v.size(); i++) begin
      if (k < 0 && log_v[i]) k = i;
      if (log_b[i]) cnt++;
    end
    chk("t1_start_found", int'(k >= 0 && k + 3 < log_v.size()), 1);
    if (k >= 0 && k + 3 < log_v.size()) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("t1_valid%0d", j), int'(log_v[k+j]), 1);
        chk($sformatf("t1_data%0d", j), int'(log_d[k+j]), int'(t1_exp[j]));
        chk($sformatf("t1_last%0d", j), int'(log_l[k+j]), int'(j == 3));
      end
    end
    chk("t1_busy_cycles", cnt, 3);

    // All four channels, two 2-byte packets each, queued from reset.
    apply_reset();
    clear_logs(); logging = 1;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NCH; c++)
        add_pkt(c, 2, 8'(16 * c + 4 * p + 1), 8'h01);
    model_release();
    wait_drain("t2", 300);
    logging = 0;
    collect_grants();
    chk("t2_grant_count", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      chk($sformatf("t2_grant%0d", i), grants[i], i % NCH);

    // Channel 2 in flight while channels 0 and 3 start requesting.
    apply_reset();
    clear_logs(); logging = 1;
    add_pkt(2, 6, 8'h21, 8'h01);
    model_release();
    wait_grant("t3_ch2", 2, 20);
    add_pkt(0, 2, 8'h01, 8'h01);
    add_pkt(3, 2, 8'h31, 8'h01);
    model_release();
    wait_drain("t3", 200);
    logging = 0;
    collect_grants();
    chk("t3_grant_count", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("t3_grant0", grants[0], 2);
      chk("t3_grant1", grants[1], 3);
      chk("t3_grant2", grants[2], 0);
    end

    // 200 random packets under random backpressure.
    apply_reset();
    for (int p = 0; p < 200; p++)
      add_pkt($urandom_range(0, NCH - 1), $urandom_range(1, 4), 8'($urandom_range(0, 255)), 8'h01);
    model_release();
    rand_ready = 1;
    wait_drain("t4", 6000);
    rand_ready = 0;

    // No-ID instance: back-to-back one-byte packets on channels 1 and 2.
    apply_reset();
    clear_logs(); logging = 1;
    s0_d[1].push_back(8'h55); s0_l[1].push_back(1'b1);
    s0_d[2].push_back(8'h66); s0_l[2].push_back(1'b1);
    repeat (12) @(negedge aclk);
    logging = 0;
    k = -1; cnt = 0;
    for (int i = 0; i < log_v0.size(); i++) begin
      if (k < 0 && log_v0[i]) k = i;
      if (log_v0[i]) cnt++;
    end
    chk("t5_valid_beats", cnt, 2);
    chk("t5_start_found", int'(k >= 0 && k + 2 < log_v0.size()), 1);
    if (k >= 0 && k + 2 < log_v0.size()) begin
      chk("t5_data0", int'(log_d0[k]), 8'h55);
      chk("t5_last0", int'(log_l0[k]), 1);
      chk("t5_bubble", int'(log_v0[k+1]), 0);
      chk("t5_valid1", int'(log_v0[k+2]), 1);
      chk("t5_data1", int'(log_d0[k+2]), 8'h66);
      chk("t5_last1", int'(log_l0[k+2]), 1);
    end

    // Reset mid-packet on channel 1, then a fresh channel-1 packet.
    apply_reset();
    add_pkt(1, 8, 8'h71, 8'h01);
    model_release();
    wait_grant("t6_ch1", 1, 20);
    repeat (3) @(negedge aclk);
    chk("t6_midpacket_valid", int'(ov), 1);
    apply_reset();
    clear_logs(); logging = 1;
    add_pkt(1, 2, 8'h5A, 8'h01);
    model_release();
    wait_drain("t6", 50);
    logging = 0;
    k = -1;
    for (int i = 0; i < log_v.size(); i++) if (k < 0 && log_v[i]) k = i;
    chk("t6_start_found", int'(k >= 0 && k + 2 < log_v.size()), 1);
    if (k >= 0 && k + 2 < log_v.size()) begin
      chk("t6_id", int'(log_d[k]), 8'hA1);
      chk("t6_data0", int'(log_d[k+1]), 8'h5A);
      chk("t6_data1", int'(log_d[k+2]), 8'h5B);
      chk("t6_last", int'(log_l[k+2]), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
